// File: rtl/hazard_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_pipe_ctrl
//  Brief   : Tracks register indices and write-enables of in-flight
//            instructions through ID/EX, EX/MEM and MEM/WB. Detects load-use
//            hazards (one-cycle stall plus bubble), squashes ID on a taken
//            branch and counts load-use stall cycles with saturation.
//  Revision: 1.0 - initial release
// ============================================================================
module hazard_pipe_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_id,
  input  logic [RA_W-1:0]  rs1_id,
  input  logic [RA_W-1:0]  rs2_id,
  input  logic [RA_W-1:0]  rd_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             reg_write_id,
  input  logic             mem_read_id,
  input  logic             branch_taken_ex,
  output logic [RA_W-1:0]  rs1_ex,
  output logic [RA_W-1:0]  rs2_ex,
  output logic [RA_W-1:0]  rd_ex,
  output logic [RA_W-1:0]  rd_mem,
  output logic [RA_W-1:0]  rd_wb,
  output logic             reg_write_mem,
  output logic             reg_write_wb,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [RA_W-1:0]  c_zero_ra = '0;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  // ID/EX stage
  logic            r_ex_valid;
  logic            r_ex_reg_write;
  logic            r_ex_mem_read;
  logic [RA_W-1:0] r_ex_rs1;
  logic [RA_W-1:0] r_ex_rs2;
  logic [RA_W-1:0] r_ex_rd;

  // EX/MEM and MEM/WB stages; write-enables already exclude bubbles and x0
  logic            r_mem_reg_write;
  logic [RA_W-1:0] r_mem_rd;
  logic            r_wb_reg_write;
  logic [RA_W-1:0] r_wb_rd;

  logic [CNT_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_ex_writes;

  // Load in EX whose destination is read by the instruction waiting in ID
  assign w_load_use = en & valid_id & r_ex_valid & r_ex_mem_read &
                      (r_ex_rd != c_zero_ra) &
                      ((use_rs1_id & (rs1_id == r_ex_rd)) |
                       (use_rs2_id & (rs2_id == r_ex_rd)));

  // A taken branch overrides the stall: the dependent instruction is squashed anyway
  assign stall_if_id = w_load_use & ~branch_taken_ex;
  assign flush_if_id = en & branch_taken_ex;
  assign w_bubble    = branch_taken_ex | w_load_use;

  // x0 writes are reported as no write at all
  assign w_ex_writes = r_ex_reg_write & (r_ex_rd != c_zero_ra);

  // ID/EX register: bubble on hazard or branch, otherwise capture the ID fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
    end else if (en) begin
      if (w_bubble) begin
        r_ex_valid     <= 1'b0;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
        r_ex_rs1       <= '0;
        r_ex_rs2       <= '0;
        r_ex_rd        <= '0;
      end else begin
        r_ex_valid     <= valid_id;
        r_ex_reg_write <= valid_id & reg_write_id;
        r_ex_mem_read  <= valid_id & mem_read_id;
        r_ex_rs1       <= rs1_id;
        r_ex_rs2       <= rs2_id;
        r_ex_rd        <= rd_id;
      end
    end
  end

  // EX/MEM and MEM/WB registers always advance when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_reg_write <= 1'b0;
      r_mem_rd        <= '0;
      r_wb_reg_write  <= 1'b0;
      r_wb_rd         <= '0;
    end else if (en) begin
      r_mem_reg_write <= w_ex_writes;
      r_mem_rd        <= w_ex_writes ? r_ex_rd : c_zero_ra;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_rd         <= r_mem_rd;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_if_id && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign rs1_ex        = r_ex_rs1;
  assign rs2_ex        = r_ex_rs2;
  assign rd_ex         = r_ex_rd;
  assign rd_mem        = r_mem_rd;
  assign rd_wb         = r_wb_rd;
  assign reg_write_mem = r_mem_reg_write;
  assign reg_write_wb  = r_wb_reg_write;
  assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hazard_pipe_ctrl
//  Brief   : Self-checking bench for hazard_pipe_ctrl. An instruction-level
//            model of the pipeline is compared against the DUT every cycle,
//            with directed scenarios pinned by literal expectations and a
//            randomized phase. A second instance with a 2-bit counter covers
//            saturation.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, valid_id, use_rs1_id, use_rs2_id, reg_write_id, mem_read_id, branch_taken_ex;
  logic [4:0] rs1_id, rs2_id, rd_id;

  logic [4:0]  rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic        reg_write_mem, reg_write_wb, stall_if_id, flush_if_id;
  logic [15:0] stall_cnt;

  logic [4:0]  rs1_ex2, rs2_ex2, rd_ex2, rd_mem2, rd_wb2;
  logic        reg_write_mem2, reg_write_wb2, stall_if_id2, flush_if_id2;
  logic [1:0]  stall_cnt2;

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(.RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
    .branch_taken_ex(branch_taken_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .stall_cnt(stall_cnt)
  );

  hazard_pipe_ctrl #(.RA_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
    .branch_taken_ex(branch_taken_ex),
    .rs1_ex(rs1_ex2), .rs2_ex(rs2_ex2), .rd_ex(rd_ex2), .rd_mem(rd_mem2), .rd_wb(rd_wb2),
    .reg_write_mem(reg_write_mem2), .reg_write_wb(reg_write_wb2),
    .stall_if_id(stall_if_id2), .flush_if_id(flush_if_id2), .stall_cnt(stall_cnt2)
  );

  // Instruction record: what an in-flight instruction carries down the pipe
  typedef struct {
    bit       v;
    bit [4:0] rs1, rs2, rd;
    bit       wr, ld;
  } instr_t;

  instr_t      pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
  int unsigned nstall;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    return en && valid_id && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
           ((use_rs1_id && rs1_id == pipe[0].rd) || (use_rs2_id && rs2_id == pipe[0].rd));
  endfunction

  function automatic int dest_of(input instr_t i);
    return (i.v && i.wr && i.rd != 0) ? int'(i.rd) : 0;
  endfunction

  task automatic model_reset();
    instr_t z;
    z = '{default: 0};
    for (int k = 0; k < 3; k++) pipe[k] = z;
    nstall = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    instr_t nxt;
    bit lu;
    lu = model_load_use();
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (lu && !branch_taken_ex) nstall++;
      nxt = '{default: 0};
      if (!(branch_taken_ex || lu)) begin
        nxt.v   = valid_id;
        nxt.rs1 = rs1_id;
        nxt.rs2 = rs2_id;
        nxt.rd  = rd_id;
        nxt.wr  = valid_id && reg_write_id;
        nxt.ld  = valid_id && mem_read_id;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
  endtask

  task automatic compare_all();
    bit lu;
    lu = model_load_use();
    chk("rs1_ex", rs1_ex, pipe[0].rs1);
    chk("rs2_ex", rs2_ex, pipe[0].rs2);
    chk("rd_ex", rd_ex, pipe[0].rd);
    chk("rd_mem", rd_mem, dest_of(pipe[1]));
    chk("rd_wb", rd_wb, dest_of(pipe[2]));
    chk("reg_write_mem", reg_write_mem, int'(dest_of(pipe[1]) != 0));
    chk("reg_write_wb", reg_write_wb, int'(dest_of(pipe[2]) != 0));
    chk("stall_if_id", stall_if_id, int'(lu && !branch_taken_ex));
    chk("flush_if_id", flush_if_id, int'(en && branch_taken_ex));
    chk("stall_cnt", stall_cnt, (nstall > 65535) ? 65535 : int'(nstall));
    chk("stall_cnt_sat2", stall_cnt2, (nstall > 3) ? 3 : int'(nstall));
  endtask

  // One cycle: model check mid-cycle, then both DUT and model take the edge
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input bit v, input bit [4:0] a, input bit [4:0] b, input bit [4:0] d,
                     input bit u1, input bit u2, input bit wr, input bit ld, input bit br);
    rst = 1'b0; en = 1'b1;
    valid_id = v; rs1_id = a; rs2_id = b; rd_id = d;
    use_rs1_id = u1; use_rs2_id = u2; reg_write_id = wr; mem_read_id = ld;
    branch_taken_ex = br;
  endtask

  int unsigned cnt_before;

  initial begin
    rst = 1'b1; en = 1'b0; valid_id = 1'b0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
    reg_write_id = 1'b0; mem_read_id = 1'b0; branch_taken_ex = 1'b0;
    rs1_id = '0; rs2_id = '0; rd_id = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held for two cycles
    tick(); tick();
    chk("reset_rd_ex", rd_ex, 0);
    chk("reset_rd_mem", rd_mem, 0);
    chk("reset_rd_wb", rd_wb, 0);
    chk("reset_rw_wb", reg_write_wb, 0);
    chk("reset_cnt", stall_cnt, 0);

    // add x5 flows EX -> MEM -> WB
    drv(1, 1, 2, 5, 1, 1, 1, 0, 0); tick();
    chk("flow_rd_ex", rd_ex, 5);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("flow_rd_mem", rd_mem, 5);
    chk("flow_rw_mem", reg_write_mem, 1);
    tick();
    chk("flow_rd_wb", rd_wb, 5);
    chk("flow_rw_wb", reg_write_wb, 1);

    // lw x3 then add x4,x3,x1: one stall, bubble, then the add proceeds
    drv(1, 0, 0, 3, 1, 0, 1, 1, 0); tick();
    drv(1, 3, 1, 4, 1, 1, 1, 0, 0); #1;
    chk("lu_stall", stall_if_id, 1);
    tick();
    chk("lu_bubble_rd_ex", rd_ex, 0);
    chk("lu_rd_mem", rd_mem, 3);
    chk("lu_cnt", stall_cnt, 1);
    #1;
    chk("lu_stall_released", stall_if_id, 0);
    tick();
    chk("lu_rs1_ex", rs1_ex, 3);
    chk("lu_rd_ex", rd_ex, 4);
    chk("lu_rd_wb", rd_wb, 3);

    // No false stalls: load to x0, and an unused rs2 matching the load target
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    drv(1, 0, 0, 8, 1, 1, 1, 0, 0); #1;
    chk("nofalse_x0", stall_if_id, 0);
    tick();
    drv(1, 0, 0, 6, 1, 0, 1, 1, 0); tick();
    drv(1, 1, 6, 9, 1, 0, 1, 0, 0); #1;
    chk("nofalse_rs2", stall_if_id, 0);
    tick();

    // Branch beats load-use
    drv(1, 0, 0, 7, 0, 0, 1, 1, 0); tick();
    cnt_before = nstall;
    drv(1, 7, 0, 10, 1, 0, 1, 0, 1); #1;
    chk("br_stall", stall_if_id, 0);
    chk("br_flush", flush_if_id, 1);
    tick();
    chk("br_bubble_rd_ex", rd_ex, 0);
    chk("br_cnt", stall_cnt, cnt_before);

    // Freeze: issue add x9 then hold for 3 cycles
    drv(1, 2, 3, 9, 1, 1, 1, 0, 0); tick();
    en = 1'b0; valid_id = 1'b1; rd_id = 5'd12; branch_taken_ex = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("freeze_rd_ex", rd_ex, 9);
      chk("freeze_flush", flush_if_id, 0);
    end

    // Reset during a stall, then five stalls for saturation of the 2-bit counter
    drv(1, 0, 0, 2, 0, 0, 1, 1, 0); tick();
    drv(1, 2, 0, 3, 1, 0, 1, 0, 0); rst = 1'b1; tick();
    chk("midrst_cnt", stall_cnt, 0);
    chk("midrst_rd_ex", rd_ex, 0);
    for (int k = 0; k < 5; k++) begin
      drv(1, 0, 0, 2, 0, 0, 1, 1, 0); tick();
      drv(1, 2, 0, 3, 1, 0, 1, 0, 0); tick(); tick();
    end
    chk("sat_cnt16", stall_cnt, 5);
    chk("sat_cnt2", stall_cnt2, 3);

    // Randomized traffic with a small register range to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      rst             = ($urandom_range(0, 99) == 0);
      en              = ($urandom_range(0, 9) != 0);
      valid_id        = ($urandom_range(0, 9) != 0);
      rs1_id          = 5'($urandom_range(0, 3));
      rs2_id          = 5'($urandom_range(0, 3));
      rd_id           = 5'($urandom_range(0, 3));
      use_rs1_id      = 1'($urandom);
      use_rs2_id      = 1'($urandom);
      reg_write_id    = ($urandom_range(0, 3) != 0);
      mem_read_id     = ($urandom_range(0, 9) < 4);
      branch_taken_ex = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
